// File: rtl/bcd_disp_pkg.sv
// Shared types, segment constants and the BCD-to-segment mapping for the
// seven-segment scan driver. Segment order is {g,f,e,d,c,b,a}, active-high.
package bcd_disp_pkg;

  typedef enum logic {
    S_GUARD,
    S_DRIVE
  } state_t;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Non-decimal codes 10..15 show a dash so corrupt data is visible.
  function automatic logic [6:0] bcd2seg(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-high seven-segment decoder.
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Pure table lookup; no state.
  always_comb begin
    seg_o = bcd2seg(bcd_i);
  end

endmodule

// File: rtl/bcd_seg_scan_driver.sv
// Time-multiplexed seven-segment driver with guard time and frame-synchronous
// word update. Optional macro BCD_LZB_EN enables leading-zero blanking.
module bcd_seg_scan_driver
  import bcd_disp_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter int GUARD_CYC      = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NUM_DIGITS-1:0] in_bcd,
  input  logic [NUM_DIGITS-1:0]   in_dp,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_done
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0]            SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_INV  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] DIG_INV = (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [4*NUM_DIGITS-1:0] pend_bcd_q, pend_bcd_d, disp_bcd_q, disp_bcd_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;
  logic                    frame_done_q;
  logic                    frame_end;
  logic [3:0]              cur_digit;
  logic                    cur_dp;
  logic [6:0]              dec_seg;
  logic                    blank;

  assign in_ready   = ~pend_valid_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign dig_en     = dig_en_q;
  assign frame_done = frame_done_q;

  assign frame_end = (state_q == S_DRIVE) && (cnt_q == CNT_W'(CLK_DIV - 1)) &&
                     (idx_q == IDX_W'(NUM_DIGITS - 1));

  // Slot sequencing: guard phase, then drive phase, then advance digit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    case (state_q)
      S_GUARD: begin
        if (cnt_q == CNT_W'(GUARD_CYC - 1)) state_d = S_DRIVE;
      end
      S_DRIVE: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          state_d = S_GUARD;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
      end
      default: state_d = S_GUARD;
    endcase
  end

  // Pending buffer accepts when empty; display takes it only at frame end.
  // A full buffer is never accepted into, so accept and commit cannot collide.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_bcd_d   = pend_bcd_q;
    pend_dp_d    = pend_dp_q;
    disp_bcd_d   = disp_bcd_q;
    disp_dp_d    = disp_dp_q;
    if (frame_end && pend_valid_q) begin
      disp_bcd_d   = pend_bcd_q;
      disp_dp_d    = pend_dp_q;
      pend_valid_d = 1'b0;
    end
    if (in_valid && !pend_valid_q) begin
      pend_bcd_d   = in_bcd;
      pend_dp_d    = in_dp;
      pend_valid_d = 1'b1;
    end
  end

  // Select the digit that will be driven next cycle, so the registered
  // outputs line up with the registered state.
  always_comb begin
    cur_digit = 4'd0;
    cur_dp    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        cur_digit = disp_bcd_q[4*i +: 4];
        cur_dp    = disp_dp_q[i];
      end
    end
  end

  bcd_to_7seg u_dec (
    .bcd_i (cur_digit),
    .seg_o (dec_seg)
  );

`ifdef BCD_LZB_EN
  logic [NUM_DIGITS-1:0] lead_zero;
  logic                  zero_run;

  // A digit is a leading zero when it and every more significant digit are 0;
  // digit 0 always shows.
  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run     = zero_run && (disp_bcd_q[4*i +: 4] == 4'd0);
      lead_zero[i] = zero_run;
    end
    blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) blank = lead_zero[i];
    end
  end
`else
  assign blank = 1'b0;
`endif

  // Active-high output values for next cycle; off during guard.
  always_comb begin
    seg_d    = SEG_OFF;
    dp_d     = 1'b0;
    dig_en_d = '0;
    if (state_d == S_DRIVE) begin
      seg_d           = blank ? SEG_OFF : dec_seg;
      dp_d            = cur_dp;
      dig_en_d[idx_d] = 1'b1;
    end
  end

  // State, buffers and output registers; polarity applied only here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_GUARD;
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_bcd_q   <= '0;
      pend_dp_q    <= '0;
      disp_bcd_q   <= '0;
      disp_dp_q    <= '0;
      seg_q        <= SEG_INV;
      dp_q         <= DP_INV;
      dig_en_q     <= DIG_INV;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_valid_q <= pend_valid_d;
      pend_bcd_q   <= pend_bcd_d;
      pend_dp_q    <= pend_dp_d;
      disp_bcd_q   <= disp_bcd_d;
      disp_dp_q    <= disp_dp_d;
      seg_q        <= seg_d ^ SEG_INV;
      dp_q         <= dp_d ^ DP_INV;
      dig_en_q     <= dig_en_d ^ DIG_INV;
      frame_done_q <= frame_end;
    end
  end

endmodule
